// File: rtl/pll_cen_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_cen_gen
// Description : Phase-accumulator clock-enable generator with shadowed,
//               simultaneously applied per-channel increments and lock status.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_cen_gen #(
  parameter int                          CHANNELS = 5,
  parameter int                          ACC_W    = 32,
  parameter int                          SETTLE   = 16,
  parameter logic [CHANNELS*ACC_W-1:0]   INIT_INC = '0
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic                cfg_apply,
  output logic [CHANNELS-1:0] cen,
  output logic [CHANNELS-1:0] clk_sq,
  output logic                locked
);

  localparam int                 c_CNT_W  = $clog2(SETTLE + 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE = c_CNT_W'(SETTLE);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_locked;
  logic               w_ch_ok;

  assign w_ch_ok = ({1'b0, cfg_ch} < 5'(CHANNELS));
  assign locked  = r_locked;

  // Settle counter: reloaded by reset or apply, counts down only while unlocked.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_cnt    <= c_SETTLE;
      r_locked <= 1'b0;
    end else if (cfg_apply) begin
      r_cnt    <= c_SETTLE;
      r_locked <= 1'b0;
    end else if (!r_locked) begin
      if (r_cnt == c_ONE) begin
        r_locked <= 1'b1;
      end
      r_cnt <= r_cnt - c_ONE;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] r_shadow;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_acc;
    logic             r_cen;
    logic             w_sel;
    logic [ACC_W:0]   w_sum;

    assign w_sel = cfg_we && w_ch_ok && (cfg_ch == 4'(i));
    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    // Accumulator stays cleared while unlocked so every channel restarts in phase.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        r_shadow <= INIT_INC[i*ACC_W +: ACC_W];
        r_inc    <= INIT_INC[i*ACC_W +: ACC_W];
        r_acc    <= '0;
        r_cen    <= 1'b0;
      end else begin
        if (w_sel) begin
          r_shadow <= cfg_inc;
        end
        if (cfg_apply) begin
          r_inc <= w_sel ? cfg_inc : r_shadow;
          r_acc <= '0;
          r_cen <= 1'b0;
        end else if (r_locked) begin
          r_acc <= w_sum[ACC_W-1:0];
          r_cen <= w_sum[ACC_W];
        end else begin
          r_acc <= '0;
          r_cen <= 1'b0;
        end
      end
    end

    assign cen[i]    = r_cen;
    assign clk_sq[i] = r_acc[ACC_W-1];
  end

endmodule
`default_nettype wire
